mdu: RTL and testbench

Multi-cycle multiply/divide unit for the P6 pipeline, placed in EX beside the combinational ALU. It executes mult, multu, div, divu, mthi and mtlo against its private HI/LO register pair and provides mfhi/mflo read data. It raises `busy` while an operation is in flight so the hazard unit can stall any later HI/LO instruction.

---
 rtl/mdu_if.sv | 29 ++
 rtl/mdu.sv | 147 ++++++++++++++
 tb/tb_mdu.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/mdu_if.sv
// mdu_if: bus between the EX stage and the multiply/divide unit.
//   A, B      : operands (rs, rt), sampled only when an op starts
//   MDUOp     : operation code (NONE/MULT/MULTU/DIV/DIVU/MTHI/MTLO)
//   start     : MDUOp is valid this cycle
//   hilo_sel  : read select for out, 0 = LO, 1 = HI
//   busy      : an operation is in flight
//   out       : hilo_sel ? HI : LO
//   HI, LO    : committed architectural registers
interface mdu_if;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  MDUOp;
    logic        start;
    logic        hilo_sel;
    logic        busy;
    logic [31:0] out;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (
        output A, B, MDUOp, start, hilo_sel,
        input  busy, out, HI, LO
    );

    modport slave (
        input  A, B, MDUOp, start, hilo_sel,
        output busy, out, HI, LO
    );
endinterface

// File: rtl/mdu.sv
// mdu: multi-cycle multiply/divide unit with private HI/LO registers.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : mdu_if slave port (operands, op, start, read select, busy, out, HI, LO)
// A mult/div computes its result at start into shadow registers, then
// counts down MULT_CYCLES/DIV_CYCLES edges and commits on the last one.
// MTHI/MTLO write immediately when idle. Starts seen while running are dropped.
module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic clk,
    input  logic rst_n,
    mdu_if.slave bus
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state, state_nx;
    logic [3:0]  cnt, cnt_nx;
    logic [31:0] hi_n, hi_n_nx;
    logic [31:0] lo_n, lo_n_nx;
    logic [31:0] hi_r, hi_nx;
    logic [31:0] lo_r, lo_nx;

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        div_zero;
    logic        div_ovf;
    logic [31:0] divisor_s;
    logic [31:0] divisor_u;
    logic [31:0] quot_s, rem_s;
    logic [31:0] quot_u, rem_u;

    // Full-width products: sign extension for MULT, zero extension for MULTU.
    assign prod_s = $signed({{32{bus.A[31]}}, bus.A}) * $signed({{32{bus.B[31]}}, bus.B});
    assign prod_u = {32'd0, bus.A} * {32'd0, bus.B};

    // Divide by zero and the signed -2^31 / -1 overflow never reach the
    // divider; the divisor is replaced by 1 so no X or host trap can occur,
    // and the real results for those cases are muxed in below.
    assign div_zero  = (bus.B == 32'd0);
    assign div_ovf   = (bus.A == 32'h8000_0000) && (bus.B == 32'hFFFF_FFFF);
    assign divisor_s = (div_zero || div_ovf) ? 32'd1 : bus.B;
    assign divisor_u = div_zero ? 32'd1 : bus.B;

    // Signed quotient truncates toward zero; remainder follows the dividend.
    always_comb begin
        quot_s = 32'($signed(bus.A) / $signed(divisor_s));
        rem_s  = 32'($signed(bus.A) % $signed(divisor_s));
        if (div_ovf) begin
            quot_s = 32'h8000_0000;
            rem_s  = 32'd0;
        end
    end

    assign quot_u = bus.A / divisor_u;
    assign rem_u  = bus.A % divisor_u;

    // State register plus counter, shadow and committed registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 4'd0;
            hi_n  <= 32'd0;
            lo_n  <= 32'd0;
            hi_r  <= 32'd0;
            lo_r  <= 32'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            hi_n  <= hi_n_nx;
            lo_n  <= lo_n_nx;
            hi_r  <= hi_nx;
            lo_r  <= lo_nx;
        end
    end

    // Next-state logic. In IDLE a start launches an op or writes HI/LO
    // directly; in RUN the counter runs down and the shadow pair is
    // committed on the edge where it reaches zero.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        hi_n_nx  = hi_n;
        lo_n_nx  = lo_n;
        hi_nx    = hi_r;
        lo_nx    = lo_r;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    case (bus.MDUOp)
                        OP_MULT: begin
                            {hi_n_nx, lo_n_nx} = prod_s;
                            cnt_nx   = 4'(MULT_CYCLES);
                            state_nx = RUN;
                        end
                        OP_MULTU: begin
                            {hi_n_nx, lo_n_nx} = prod_u;
                            cnt_nx   = 4'(MULT_CYCLES);
                            state_nx = RUN;
                        end
                        OP_DIV: begin
                            hi_n_nx  = div_zero ? hi_r : rem_s;
                            lo_n_nx  = div_zero ? lo_r : quot_s;
                            cnt_nx   = 4'(DIV_CYCLES);
                            state_nx = RUN;
                        end
                        OP_DIVU: begin
                            hi_n_nx  = div_zero ? hi_r : rem_u;
                            lo_n_nx  = div_zero ? lo_r : quot_u;
                            cnt_nx   = 4'(DIV_CYCLES);
                            state_nx = RUN;
                        end
                        OP_MTHI: hi_nx = bus.A;
                        OP_MTLO: lo_nx = bus.A;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                cnt_nx = cnt - 4'd1;
                // cnt <= 1 rather than == 1 so a zero count can never wedge RUN.
                if (cnt <= 4'd1) begin
                    cnt_nx   = 4'd0;
                    hi_nx    = hi_n;
                    lo_nx    = lo_n;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign bus.busy = (state == RUN);
    assign bus.HI   = hi_r;
    assign bus.LO   = lo_r;
    assign bus.out  = bus.hilo_sel ? hi_r : lo_r;

endmodule

// File: tb/tb_mdu.sv
// tb_mdu: directed, table-driven self-checking bench for mdu.
// A vector table covers the mult/div arithmetic and latency; hand-written
// sequences cover reset, divide-by-zero, starts during RUN and reset abort.
module tb_mdu;

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;

    logic clk;
    logic rst_n;
    int   compared;
    int   mismatched;

    mdu_if bus ();

    mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } vec_t;

    vec_t vecs[8];

    // Compare one value and log a FAIL line on mismatch.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Present one op for a single edge, then return #1 after that edge.
    task automatic issueOp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.MDUOp = op;
        bus.A     = a;
        bus.B     = b;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.MDUOp = OP_NONE;
    endtask

    // Launch an op and count the cycles busy stays high, bounded at 40.
    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a,
                                 input logic [31:0] b, output int busyCycles);
        int guard;
        issueOp(op, a, b);
        busyCycles = 0;
        guard = 0;
        while (bus.busy === 1'b1 && guard < 40) begin
            busyCycles++;
            guard++;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int busyCycles;
        compared   = 0;
        mismatched = 0;

        vecs[0] = '{"mult_neg2x3",   OP_MULT,  32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA, 5};
        vecs[1] = '{"multu_neg2x3",  OP_MULTU, 32'hFFFF_FFFE, 32'd3,         32'h0000_0002, 32'hFFFF_FFFA, 5};
        vecs[2] = '{"mult_maxpos",   OP_MULT,  32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 5};
        vecs[3] = '{"div_neg7by2",   OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
        vecs[4] = '{"divu_7by2",     OP_DIVU,  32'd7,         32'd2,         32'd1,         32'd3,         10};
        vecs[5] = '{"div_7byneg2",   OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 10};
        vecs[6] = '{"divu_big",      OP_DIVU,  32'hFFFF_FFFF, 32'h10,        32'h0000_000F, 32'h0FFF_FFFF, 10};
        vecs[7] = '{"div_overflow",  OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10};

        bus.A        = 32'd0;
        bus.B        = 32'd0;
        bus.MDUOp    = OP_NONE;
        bus.start    = 1'b0;
        bus.hilo_sel = 1'b0;
        rst_n        = 1'b1;

        // Reset asserted mid-cycle must clear outputs without a clock edge.
        #12;
        rst_n = 1'b0;
        #1;
        checkOutput("reset_hi",   bus.HI,           32'd0);
        checkOutput("reset_lo",   bus.LO,           32'd0);
        checkOutput("reset_busy", {31'd0, bus.busy}, 32'd0);
        checkOutput("reset_out",  bus.out,          32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("idle_busy", {31'd0, bus.busy}, 32'd0);

        // Table-driven arithmetic and latency.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, busyCycles);
            checkOutput({vecs[i].name, "_cycles"}, 32'(busyCycles), 32'(vecs[i].cycles));
            checkOutput({vecs[i].name, "_hi"}, bus.HI, vecs[i].hi);
            checkOutput({vecs[i].name, "_lo"}, bus.LO, vecs[i].lo);
            bus.hilo_sel = 1'b1;
            #1;
            checkOutput({vecs[i].name, "_out_hi"}, bus.out, vecs[i].hi);
            bus.hilo_sel = 1'b0;
            #1;
            checkOutput({vecs[i].name, "_out_lo"}, bus.out, vecs[i].lo);
        end

        // Divide by zero keeps preloaded HI/LO but still runs the full count.
        issueOp(OP_MTHI, 32'h11, 32'd0);
        checkOutput("mthi_hi",   bus.HI,            32'h11);
        checkOutput("mthi_busy", {31'd0, bus.busy}, 32'd0);
        issueOp(OP_MTLO, 32'h22, 32'd0);
        checkOutput("mtlo_lo", bus.LO, 32'h22);
        applyStimulus(OP_DIV, 32'd5, 32'd0, busyCycles);
        checkOutput("divzero_cycles", 32'(busyCycles), 32'd10);
        checkOutput("divzero_hi", bus.HI, 32'h11);
        checkOutput("divzero_lo", bus.LO, 32'h22);

        // Starts during RUN are dropped: MULT 2x3 at edge t, MTLO at t+2, DIV at t+3.
        issueOp(OP_MULT, 32'd2, 32'd3);
        checkOutput("busyrun_t1", {31'd0, bus.busy}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.MDUOp = OP_MTLO; bus.A = 32'hDEAD; bus.start = 1'b1;
        @(negedge clk);
        bus.MDUOp = OP_DIV; bus.A = 32'd9; bus.B = 32'd2;
        @(negedge clk);
        bus.start = 1'b0; bus.MDUOp = OP_NONE;
        checkOutput("busyrun_lo_held", bus.LO, 32'h22);
        @(posedge clk);
        #1;
        checkOutput("busyrun_t4", {31'd0, bus.busy}, 32'd1);
        @(posedge clk);
        #1;
        checkOutput("busyrun_t5", {31'd0, bus.busy}, 32'd0);
        checkOutput("busyrun_lo", bus.LO, 32'd6);
        checkOutput("busyrun_hi", bus.HI, 32'd0);
        issueOp(OP_MTHI, 32'h77, 32'd0);
        checkOutput("after_mthi", bus.HI, 32'h77);
        checkOutput("after_mthi_busy", {31'd0, bus.busy}, 32'd0);

        // Reset mid-RUN aborts the divide with no later commit.
        issueOp(OP_DIVU, 32'd100, 32'd7);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", {31'd0, bus.busy}, 32'd0);
        checkOutput("abort_hi",   bus.HI, 32'd0);
        checkOutput("abort_lo",   bus.LO, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        checkOutput("abort_late_hi",   bus.HI, 32'd0);
        checkOutput("abort_late_lo",   bus.LO, 32'd0);
        checkOutput("abort_late_busy", {31'd0, bus.busy}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
